// File: rtl/class_hv_trainer.sv
// class_hv_trainer: accumulates training hypervectors into per-dimension
// counters and majority-thresholds them into a class prototype.
module class_hv_trainer #(
  parameter int DIMENSIONS = 10000,
  parameter int CW         = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  clear,
  input  logic                  en,
  input  logic                  finalize,
  input  logic [DIMENSIONS-1:0] hv_in,
  output logic                  done,
  output logic [DIMENSIONS-1:0] hv_class,
  output logic [CW-1:0]         sample_count
);

  localparam int AW = $clog2(DIMENSIONS);
  localparam int DW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FINAL
  } state_e;

  state_e                state_q, state_d;
  logic [DW-1:0]         d_q;
  logic [DIMENSIONS-1:0] lat_q;
  logic [DIMENSIONS-1:0] shadow_q;
  logic [DIMENSIONS-1:0] class_q;
  logic [CW-1:0]         sc_q;
  logic [CW-1:0]         cnt_q [DIMENSIONS];
  logic                  done_q;

  logic                  do_clr;
  logic                  do_fin;
  logic                  do_acc;
  logic                  last;
  logic [AW-1:0]         idx;

  // clear outranks finalize, which outranks en
  assign do_clr = clear;
  assign do_fin = finalize & ~clear;
  assign do_acc = en & ~clear & ~finalize;

  assign last = (d_q == DW'(DIMENSIONS));
  assign idx  = d_q[AW-1:0];

  // state register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state: commands only seen in IDLE, walks end when d hits DIMENSIONS
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          do_fin:  state_d = FINAL;
          do_acc:  state_d = ACCUM;
          default: state_d = IDLE;
        endcase
      end
      ACCUM, FINAL: begin
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // datapath: one dimension per cycle, results published on terminal edge
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      d_q      <= '0;
      lat_q    <= '0;
      shadow_q <= '0;
      class_q  <= '0;
      sc_q     <= '0;
      for (int i = 0; i < DIMENSIONS; i++) cnt_q[i] <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (do_clr) begin
            sc_q <= '0;
            for (int i = 0; i < DIMENSIONS; i++) cnt_q[i] <= '0;
          end else if (do_fin || do_acc) begin
            lat_q <= hv_in;
            d_q   <= '0;
          end
        end
        ACCUM: begin
          if (!last) begin
            if (lat_q[idx] && (cnt_q[idx] != '1))
              cnt_q[idx] <= cnt_q[idx] + 1'b1;
            d_q <= d_q + 1'b1;
          end else if (sc_q != '1) begin
            sc_q <= sc_q + 1'b1;
          end
        end
        FINAL: begin
          if (!last) begin
            shadow_q[idx] <= {cnt_q[idx], 1'b0} > {1'b0, sc_q};
            d_q <= d_q + 1'b1;
          end else begin
            class_q <= shadow_q;
          end
        end
        default: ;
      endcase
    end
  end

  // done mirrors the upcoming state so it is purely registered
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      done_q <= 1'b1;
    end else begin
      done_q <= (state_d == IDLE);
    end
  end

  assign done         = done_q;
  assign hv_class     = class_q;
  assign sample_count = sc_q;

endmodule

// File: tb/tb_class_hv_trainer.sv
// tb_class_hv_trainer: randomized and directed bench for class_hv_trainer
// against an operation-level reference model.
module tb_class_hv_trainer;

  localparam int D   = 8;
  localparam int W   = 4;
  localparam int SAT = 15;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         clear = 1'b0;
  logic         en = 1'b0;
  logic         finalize = 1'b0;
  logic [D-1:0] hv_in = '0;
  logic         done;
  logic [D-1:0] hv_class;
  logic [W-1:0] sample_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  class_hv_trainer #(.DIMENSIONS(D), .CW(W)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .clear        (clear),
    .en           (en),
    .finalize     (finalize),
    .hv_in        (hv_in),
    .done         (done),
    .hv_class     (hv_class),
    .sample_count (sample_count)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: an op is busy for D+1 edges, its effect lands whole at the end
  int           m_cnt [D];
  int           m_sc   = 0;
  logic [D-1:0] m_cls  = '0;
  logic [D-1:0] m_lat  = '0;
  int           m_busy = 0;
  bit           m_fin  = 1'b0;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < D; i++) m_cnt[i] = 0;
      m_sc = 0; m_cls = '0; m_busy = 0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        if (m_fin) begin
          for (int i = 0; i < D; i++) m_cls[i] = (2 * m_cnt[i] > m_sc);
        end else begin
          for (int i = 0; i < D; i++)
            if (m_lat[i] && m_cnt[i] < SAT) m_cnt[i]++;
          if (m_sc < SAT) m_sc++;
        end
      end
    end else if (clear) begin
      for (int i = 0; i < D; i++) m_cnt[i] = 0;
      m_sc = 0;
    end else if (finalize) begin
      m_busy = D + 1; m_fin = 1'b1;
    end else if (en) begin
      m_busy = D + 1; m_fin = 1'b0; m_lat = hv_in;
    end
  end

  // per-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    chk("done", 32'(done), 32'(m_busy == 0));
    chk("hv_class", 32'(hv_class), 32'(m_cls));
    chk("sample_count", 32'(sample_count), 32'(m_sc));
  end

  // issue one command from a negedge and measure how long done stays low
  task automatic op(input bit c, input bit f, input bit e,
                    input logic [D-1:0] v, input int exp_low);
    int low;
    clear = c; finalize = f; en = e; hv_in = v;
    @(negedge clk);
    clear = 1'b0; finalize = 1'b0; en = 1'b0; hv_in = D'($urandom);
    low = 0;
    while (!done && low < 30) begin
      low++;
      @(negedge clk);
      hv_in = D'($urandom);
    end
    chk("done_low_cycles", 32'(low), 32'(exp_low));
  endtask

  initial begin
    int low;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    chk("reset_done", 32'(done), 32'd1);
    chk("reset_hv", 32'(hv_class), 32'h00);
    chk("reset_sc", 32'(sample_count), 32'd0);

    op(0, 0, 1, 8'b10101100, D + 1);
    op(0, 0, 1, 8'b10100011, D + 1);
    op(0, 0, 1, 8'b10011111, D + 1);
    op(0, 1, 0, 8'h00, D + 1);
    chk("maj_sc", 32'(sample_count), 32'd3);
    chk("maj_hv", 32'(hv_class), 32'hAF);

    op(1, 0, 0, 8'h00, 0);
    op(0, 0, 1, 8'hF0, D + 1);
    op(0, 0, 1, 8'hFF, D + 1);
    op(0, 1, 0, 8'h00, D + 1);
    chk("tie_hv", 32'(hv_class), 32'hF0);

    op(1, 0, 0, 8'h00, 0);
    for (int k = 0; k < 20; k++) op(0, 0, 1, 8'hFF, D + 1);
    op(0, 1, 0, 8'h00, D + 1);
    chk("sat_sc", 32'(sample_count), 32'd15);
    chk("sat_hv", 32'(hv_class), 32'hFF);
    op(1, 0, 0, 8'h00, 0);
    op(0, 1, 0, 8'h00, D + 1);
    chk("zero_hv", 32'(hv_class), 32'h00);

    op(0, 0, 1, 8'h3C, D + 1);
    op(1, 1, 1, 8'hFF, 0);
    chk("prio_sc", 32'(sample_count), 32'd0);
    chk("prio_hv", 32'(hv_class), 32'h00);

    en = 1'b1; hv_in = 8'h81;
    @(negedge clk);
    low = 0;
    while (!done && low < 30) begin
      low++;
      hv_in = D'($urandom);
      @(negedge clk);
    end
    en = 1'b0;
    chk("held_en_low", 32'(low), 32'(D + 1));
    chk("held_en_sc", 32'(sample_count), 32'd1);
    op(0, 1, 0, 8'h00, D + 1);
    chk("held_en_hv", 32'(hv_class), 32'h81);

    en = 1'b1; hv_in = 8'hFF;
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("abort_done", 32'(done), 32'd1);
    chk("abort_hv", 32'(hv_class), 32'h00);
    chk("abort_sc", 32'(sample_count), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    op(0, 0, 1, 8'h01, D + 1);
    op(0, 1, 0, 8'h00, D + 1);
    chk("restart_hv", 32'(hv_class), 32'h01);
    chk("restart_sc", 32'(sample_count), 32'd1);

    repeat (600) begin
      @(negedge clk);
      clear    = ($urandom_range(0, 24) == 0);
      finalize = ($urandom_range(0, 5) == 0);
      en       = ($urandom_range(0, 1) == 1);
      hv_in    = D'($urandom);
    end
    @(negedge clk);
    clear = 1'b0; finalize = 1'b0; en = 1'b0;
    repeat (D + 3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/class_hv_trainer.md
Name: class_hv_trainer

Overview:
- Builds class prototype hypervectors for the associative memory that the similarity stage compares against. Used, for example, once for the seizure class and once for the non-seizure class.
- Accumulates a stream of encoded training hypervectors into per-dimension counters, one dimension per cycle.
- On request, majority-thresholds the counters into a binary class hypervector.
- Sits between the encoder output and the stored class HVs used at inference time.

Parameters:
- DIMENSIONS, 10000, hypervector width in bits.
- CW, 8, width of each per-dimension counter and of sample_count; all counters saturate at 2^CW-1.

Ports:
- clk  input  1  rising-edge clock.
- nrst  input  1  asynchronous active-low reset.
- clear  input  1  zero all counters and sample_count; sampled only while idle.
- en  input  1  accumulate hv_in; sampled only while idle.
- finalize  input  1  threshold the counters into hv_class; sampled only while idle.
- hv_in  input  DIMENSIONS  encoded training hypervector; captured on the accept edge.
- done  output  1  1 = idle and ready; 0 = busy.
- hv_class  output  DIMENSIONS  most recently finalized class hypervector.
- sample_count  output  CW  number of accumulated samples, saturating.

Behaviour:
- Reset (nrst low, asynchronous):
  - done=1, hv_class=0, sample_count=0.
  - All per-dimension counters=0, state=IDLE, d=0.
  - Reset asserted mid-operation aborts the operation; nothing partial survives.
- States: IDLE, ACCUM, FINAL.
- IDLE command priority on a rising edge: clear > finalize > en. Lower-priority commands asserted on the same edge are dropped.
- Commands asserted while done=0 are ignored. They are not queued.
- clear (IDLE):
  - One edge; done stays 1.
  - All counters=0 and sample_count=0.
  - hv_class is unchanged.
- en (IDLE):
  - Accept edge k: hv_in latched into an internal register, d=0, done<=0, state=ACCUM.
  - Edges k+1..k+DIMENSIONS: for the current d, if latched bit d is 1, counter[d] increments (saturating); then d<=d+1.
  - Edge k+DIMENSIONS+1 (d==DIMENSIONS): sample_count increments (saturating), done<=1, state=IDLE.
  - done is therefore low for exactly DIMENSIONS+1 cycles.
  - hv_in may change freely after the accept edge.
- finalize (IDLE):
  - Same timing as en: accept edge, DIMENSIONS walk edges, one terminal edge.
  - For each d, a shadow bit = 1 iff 2*counter[d] > sample_count. Ties give 0.
  - Compare width is CW+1 bits; no overflow is allowed.
  - hv_class is loaded from the shadow atomically on the terminal edge, together with done<=1. It never shows a partial result.
  - Counters and sample_count are untouched, so accumulation may continue after a finalize.
  - sample_count==0 yields hv_class=0.
- Saturation: a counter at 2^CW-1 holds its value. sample_count holds at 2^CW-1. Thresholding uses the saturated values as-is.
- d width is $clog2(DIMENSIONS)+1 so that d can reach DIMENSIONS.
- Outputs are registered. There is no combinational path from inputs to outputs.

Test Plan:
All scenarios use DIMENSIONS=8, CW=4.
1. Reset, then idle -> done=1, hv_class=8'h00, sample_count=0. Assert nrst low mid-ACCUM -> same values immediately; the next en starts from zero counts.
2. Accumulate 8'b10101100, 8'b10100011, 8'b10011111, then finalize -> done low exactly 9 cycles per op, sample_count=3, hv_class=8'b10101111. hv_class is unchanged until the terminal edge of the finalize.
3. Tie rule: clear, accumulate 8'hF0 and 8'hFF, finalize -> hv_class=8'hF0. The low nibble has count 1, 2*1 is not >2, so those bits are 0.
4. Saturation: clear, 20 accumulates of 8'hFF, finalize -> sample_count=15, hv_class=8'hFF. Then finalize with zero samples after clear -> hv_class=8'h00.
5. Priority and busy handling:
   - clear+en+finalize together in IDLE -> only clear; done stays 1, sample_count=0.
   - en held high through an ACCUM -> exactly one sample is counted per accept.
   - Toggle hv_in during ACCUM -> counts reflect the latched value only.
